out_port_arbiter: RTL and testbench

Round-robin scheduler that shares the 4-bit output port register among NREQ requesters (ALU result path, immediate-load path, debug and similar sources). It selects one pending requester and drives the register's enable and data inputs for exactly one cycle. It then enforces a programmable hold time so each written value stays visible on the port before the next write. It sits between the processor's datapath sources and the output port register.

---
 rtl/out_port_arbiter.sv | 114 +++++++++++
 tb/tb_out_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_arbiter.sv
// Round-robin arbiter sharing the 4-bit output port register among NREQ requesters.
// Each grant is a one-cycle write; a programmable hold keeps the value visible before the next one.
module out_port_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned HOLD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] data_in,
    output logic              wr_en,
    output logic [3:0]        wr_data,
    output logic [NREQ-1:0]   gnt,
    output logic              busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] HoldInit = (HOLD == 0) ? 4'd0 : 4'(HOLD - 1);
    localparam logic [PW-1:0] PtrInit = PW'(NREQ - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          wr_en_q, wr_en_d;
    logic [3:0]    wr_data_q, wr_data_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic          busy_q, busy_d;

    logic          found;
    logic [PW-1:0] win;
    int unsigned   idx;

    // Rotating-priority search starting just after the last winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        gnt_d     = '0;
        wr_data_d = wr_data_q;
        unique case (state_q)
            StIdle: begin
                if (en && found) begin
                    state_d   = StWrite;
                    wr_en_d   = 1'b1;
                    gnt_d[win] = 1'b1;
                    wr_data_d = data_in[4*win +: 4];
                    ptr_d     = win;
                end else begin
                    wr_data_d = 4'h0;
                end
            end
            StWrite: begin
                if (HOLD == 0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StHold;
                    cnt_d   = HoldInit;
                end
            end
            StHold: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            ptr_q     <= PtrInit;
            wr_en_q   <= 1'b0;
            wr_data_q <= 4'h0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign gnt     = gnt_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter: per-cycle vector table, grant scoreboards, and hand-written
// sequences for reset and enable corner cases, on a HOLD=2 and a HOLD=0 instance.
module tb_out_port_arbiter;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  req;
    logic [15:0] data_in;

    logic        wr_en2, busy2, wr_en0, busy0;
    logic [3:0]  wr_data2, gnt2, wr_data0, gnt0;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    typedef struct {
        logic [3:0]  req;
        logic        en;
        logic [15:0] data;
        logic        wr_en;
        logic [3:0]  gnt;
        logic [3:0]  wr_data;
        logic        busy;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] data;
    } exp_t;

    vec_t vecs[18];
    exp_t q2[$];
    exp_t q0[$];
    exp_t e2, e0;
    logic mon2 = 1'b0;
    logic mon0 = 1'b0;

    out_port_arbiter #(.NREQ(4), .HOLD(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .req(req), .data_in(data_in),
        .wr_en(wr_en2), .wr_data(wr_data2), .gnt(gnt2), .busy(busy2)
    );

    out_port_arbiter #(.NREQ(4), .HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .req(req), .data_in(data_in),
        .wr_en(wr_en0), .wr_data(wr_data0), .gnt(gnt0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = 4'h0;
        step();
        reset = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [15:0] d, input logic we,
                                input logic [3:0] g, input logic [3:0] wd, input logic b);
        vec_t v;
        v.req = r; v.en = 1'b1; v.data = d;
        v.wr_en = we; v.gnt = g; v.wr_data = wd; v.busy = b;
        return v;
    endfunction

    // Scoreboards: every wr_en pulse of a monitored instance must match the next queued grant.
    always @(posedge clk) begin
        #1;
        if (mon2 && wr_en2) begin
            if (q2.size() == 0) begin
                n_total++;
                $display("FAIL sb2_extra: got gnt %b, expected no grant", gnt2);
            end else begin
                e2 = q2.pop_front();
                chk("sb2_gnt", 16'(gnt2), 16'(e2.gnt));
                chk("sb2_data", 16'(wr_data2), 16'(e2.data));
            end
        end
        if (mon0 && wr_en0) begin
            if (q0.size() == 0) begin
                n_total++;
                $display("FAIL sb0_extra: got gnt %b, expected no grant", gnt0);
            end else begin
                e0 = q0.pop_front();
                chk("sb0_gnt", 16'(gnt0), 16'(e0.gnt));
                chk("sb0_data", 16'(wr_data0), 16'(e0.data));
            end
        end
    end

    initial begin
        // Single request to 2, then rotation from ptr=2 with 1010 and 0010.
        vecs[0]  = mk(4'b0100, 16'h0A00, 1'b1, 4'b0100, 4'hA, 1'b1);
        vecs[1]  = mk(4'b0000, 16'h0A00, 1'b0, 4'b0000, 4'hA, 1'b1);
        vecs[2]  = mk(4'b0000, 16'h0A00, 1'b0, 4'b0000, 4'hA, 1'b1);
        vecs[3]  = mk(4'b0000, 16'h0A00, 1'b0, 4'b0000, 4'hA, 1'b0);
        vecs[4]  = mk(4'b0000, 16'h0A00, 1'b0, 4'b0000, 4'h0, 1'b0);
        vecs[5]  = mk(4'b0100, 16'h4321, 1'b1, 4'b0100, 4'h3, 1'b1);
        vecs[6]  = mk(4'b1010, 16'h4321, 1'b0, 4'b0000, 4'h3, 1'b1);
        vecs[7]  = mk(4'b1010, 16'h4321, 1'b0, 4'b0000, 4'h3, 1'b1);
        vecs[8]  = mk(4'b1010, 16'h4321, 1'b0, 4'b0000, 4'h3, 1'b0);
        vecs[9]  = mk(4'b1010, 16'h4321, 1'b1, 4'b1000, 4'h4, 1'b1);
        vecs[10] = mk(4'b0010, 16'h4321, 1'b0, 4'b0000, 4'h4, 1'b1);
        vecs[11] = mk(4'b0010, 16'h4321, 1'b0, 4'b0000, 4'h4, 1'b1);
        vecs[12] = mk(4'b0010, 16'h4321, 1'b0, 4'b0000, 4'h4, 1'b0);
        vecs[13] = mk(4'b0010, 16'h4321, 1'b1, 4'b0010, 4'h2, 1'b1);
        vecs[14] = mk(4'b0000, 16'h4321, 1'b0, 4'b0000, 4'h2, 1'b1);
        vecs[15] = mk(4'b0000, 16'h4321, 1'b0, 4'b0000, 4'h2, 1'b1);
        vecs[16] = mk(4'b0000, 16'h4321, 1'b0, 4'b0000, 4'h2, 1'b0);
        vecs[17] = mk(4'b0000, 16'h4321, 1'b0, 4'b0000, 4'h0, 1'b0);

        reset = 1'b1; en = 1'b1; req = 4'hF; data_in = 16'h4321;
        #2 reset = 1'b0;

        // Reset held with all requests pending, then release with en=0.
        step(); step();
        chk("rst_wr_en", 16'(wr_en2), 16'h0);
        chk("rst_gnt", 16'(gnt2), 16'h0);
        chk("rst_wr_data", 16'(wr_data2), 16'h0);
        chk("rst_busy", 16'(busy2), 16'h0);
        en = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en0_wr_en", 16'(wr_en2), 16'h0);
            chk("en0_busy", 16'(busy2), 16'h0);
        end

        for (int i = 0; i < 18; i++) begin
            req = vecs[i].req; en = vecs[i].en; data_in = vecs[i].data;
            step();
            chk($sformatf("vec%0d_wr_en", i), 16'(wr_en2), 16'(vecs[i].wr_en));
            chk($sformatf("vec%0d_gnt", i), 16'(gnt2), 16'(vecs[i].gnt));
            chk($sformatf("vec%0d_wr_data", i), 16'(wr_data2), 16'(vecs[i].wr_data));
            chk($sformatf("vec%0d_busy", i), 16'(busy2), 16'(vecs[i].busy));
        end

        // Full contention from reset: 0,1,2,3,0 with a 4-cycle pulse spacing.
        do_reset();
        q2.push_back('{4'b0001, 4'h1});
        q2.push_back('{4'b0010, 4'h2});
        q2.push_back('{4'b0100, 4'h3});
        q2.push_back('{4'b1000, 4'h4});
        q2.push_back('{4'b0001, 4'h1});
        mon2 = 1'b1;
        req = 4'hF; en = 1'b1; data_in = 16'h4321;
        for (int i = 0; i < 17; i++) begin
            step();
            chk($sformatf("cont%0d_wr_en", i), 16'(wr_en2), 16'(i % 4 == 0));
            chk($sformatf("cont%0d_busy", i), 16'(busy2), 16'(i % 4 != 3));
        end
        req = 4'h0;
        repeat (4) step();
        mon2 = 1'b0;
        chk("sb2_drained", 16'(q2.size()), 16'h0);

        // Reset asserted mid-hold after granting requester 1.
        req = 4'b0010;
        step();
        chk("mid_gnt1", 16'(gnt2), 16'b0010);
        req = 4'h0;
        step();
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_wr_data", 16'(wr_data2), 16'h0);
        chk("mid_rst_busy", 16'(busy2), 16'h0);
        chk("mid_rst_wr_en", 16'(wr_en2), 16'h0);
        chk("mid_rst_gnt", 16'(gnt2), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b1; req = 4'hF; en = 1'b1;
        step();
        chk("post_rst_gnt", 16'(gnt2), 16'b0001);
        chk("post_rst_data", 16'(wr_data2), 16'h1);
        req = 4'h0;
        repeat (4) step();

        // HOLD=0: back-to-back alternation, then en dropped during a write.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            q0.push_back('{4'b0001, 4'h5});
            q0.push_back('{4'b0010, 4'hC});
        end
        mon0 = 1'b1;
        req = 4'b0011; en = 1'b1; data_in = 16'h00C5;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("h0_%0d_wr_en", i), 16'(wr_en0), 16'(i % 2 == 0));
            chk($sformatf("h0_%0d_busy", i), 16'(busy0), 16'(i % 2 == 0));
        end
        step();
        chk("h0_grant5", 16'(wr_en0), 16'h1);
        en = 1'b0;
        step();
        chk("h0_write_done", 16'(wr_en0), 16'h0);
        chk("h0_write_busy", 16'(busy0), 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("h0_en_gate", 16'(wr_en0), 16'h0);
        end
        en = 1'b1;
        step();
        chk("h0_resume_gnt", 16'(gnt0), 16'b0010);
        req = 4'h0;
        repeat (2) step();
        mon0 = 1'b0;
        chk("sb0_drained", 16'(q0.size()), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
